// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Saturation helpers are only consumed when ADDER_SAT_EN is defined.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int MAX_W = 64;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int width);
        return MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    output logic [CHUNK-1:0] sum,
    output logic             co,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci
);

    logic [CHUNK:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign co = carry[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract, one CHUNK-bit ripple slice per pipeline stage, valid/ready handshake.
// Optional saturation on signed overflow when ADDER_SAT_EN is defined.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

    op_t              op;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             sat_in;
    logic             advance;
    logic             ovf_q;

    assign op     = op_t'(sub);
    assign b_eff  = (op == OP_SUB) ? ~b : b;
    assign c_eff  = (op == OP_SUB) ? 1'b1 : ci;
`ifdef ADDER_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // A stalled output freezes every stage, so nothing is dropped or duplicated.
    assign in_ready = rst_n & (~out_valid | out_ready);
    assign advance  = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int IW = WIDTH - k * CHUNK;   // operand bits still to be added
        localparam int LW = (k + 1) * CHUNK;     // result bits known after this stage

        logic [IW-1:0]    pa, pb;
        logic             pc, pv, psat;
        logic [CHUNK-1:0] cs;
        logic             cco;
        logic [LW-1:0]    ns, fin;
        logic             v_q, c_q;
        logic [LW-1:0]    s_q;

        if (k == 0) begin : g_src
            assign pa   = a;
            assign pb   = b_eff;
            assign pc   = c_eff;
            assign pv   = in_valid;
            assign psat = sat_in;
            assign ns   = cs;
        end else begin : g_src
            assign pa   = stg[k-1].g_mid.a_q;
            assign pb   = stg[k-1].g_mid.b_q;
            assign pc   = stg[k-1].c_q;
            assign pv   = stg[k-1].v_q;
            assign psat = stg[k-1].g_mid.sat_q;
            assign ns   = {cs, stg[k-1].s_q};
        end

        chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .sum (cs),
            .co  (cco),
            .a   (pa[CHUNK-1:0]),
            .b   (pb[CHUNK-1:0]),
            .ci  (pc)
        );

        if (k == STAGES - 1) begin : g_last
            logic ovf_n;
            assign ovf_n = ovf_calc(pa[CHUNK-1], pb[CHUNK-1], ns[LW-1]);
            assign fin   = (psat & ovf_n) ? (pa[CHUNK-1] ? SMIN : SMAX) : ns;

            always_ff @(posedge clk) begin
                if (!rst_n)       ovf_q <= 1'b0;
                else if (advance) ovf_q <= ovf_n;
            end
        end else begin : g_mid
            localparam int UW = IW - CHUNK;
            logic [UW-1:0] a_q, b_q;
            logic          sat_q;
            assign fin = ns;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sat_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= pa[IW-1:CHUNK];
                    b_q   <= pb[IW-1:CHUNK];
                    sat_q <= psat;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= pv;
                c_q <= cco;
                s_q <= fin;
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].s_q;
    assign co        = stg[STAGES-1].c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, handshake sequences and
// a randomized run against an arithmetic reference model.
module tb_pipelined_adder;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int ST = W / CH;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, ci, sub, sat, out_valid, out_ready, co, ovf;
    logic [W-1:0] a, b, sum;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
`ifdef ADDER_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         ci, sub, sat;
        logic [W-1:0] e_sum;
        logic         e_co, e_ovf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    res_t q[$];
    vec_t tbl[$];
    logic held = 1'b0;
    res_t held_val;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ici, input logic isub, input logic isat);
        res_t r;
        int   ua, ub, sa, sb, u, s;
        logic sat_on;
`ifdef ADDER_SAT_EN
        sat_on = isat;
`else
        sat_on = 1'b0;
`endif
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        if (isub) begin
            u    = ua - ub;
            s    = sa - sb;
            r.co = (ua >= ub);
        end else begin
            u    = ua + ub + int'(ici);
            s    = sa + sb + int'(ici);
            r.co = (u > 65535);
        end
        r.sum = W'(u & 32'hFFFF);
        r.ovf = (s > 32767) || (s < -32768);
        if (sat_on && r.ovf) r.sum = (sa < 0) ? 16'h8000 : 16'h7FFF;
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci,
                                input logic vsub, input logic vsat, input logic [W-1:0] es,
                                input logic eco, input logic eovf);
        vec_t v;
        v.a = va; v.b = vb; v.ci = vci; v.sub = vsub; v.sat = vsat;
        v.e_sum = es; v.e_co = eco; v.e_ovf = eovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: evaluate the handshake before the edge, update the scoreboard, advance to next negedge.
    task automatic tick(output logic acc);
        logic exp_rdy;
        res_t r;
        #1;
        exp_rdy = rst_n && (!out_valid || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        if (rst_n && out_valid && !out_ready) chk("stall_ready", in_ready, 0);
        if (held && rst_n) begin
            chk("hold_sum", sum, held_val.sum);
            chk("hold_co", co, held_val.co);
            chk("hold_ovf", ovf, held_val.ovf);
        end
        held         = rst_n && out_valid && !out_ready;
        held_val.sum = sum;
        held_val.co  = co;
        held_val.ovf = ovf;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got sum %0h with no outstanding beat at %0t", sum, $time);
            end else begin
                r = q.pop_front();
                chk("sb_sum", sum, r.sum);
                chk("sb_co", co, r.co);
                chk("sb_ovf", ovf, r.ovf);
                popped++;
            end
        end
        acc = in_valid && exp_rdy;
        if (acc) q.push_back(model(a, b, ci, sub, sat));
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            held = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic acc;
        int   n;
        a = v.a; b = v.b; ci = v.ci; sub = v.sub; sat = v.sat;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick(acc);
        chk("vec_accept", acc, 1);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick(acc);
            n++;
        end
        chk("latency", n, ST);
        chk("vec_sum", sum, v.e_sum);
        chk("vec_co", co, v.e_co);
        chk("vec_ovf", ovf, v.e_ovf);
        tick(acc);
    endtask

    initial begin
        logic acc;
        int   sent, cyc, base, seen;
        logic [W-1:0] picks [4];

        tbl.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        tbl.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1));
        tbl.push_back(mk(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0));
        tbl.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
        tbl.push_back(mk(16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h1236, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
        tbl.push_back(mk(16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 16'h10E0, 1'b0, 1'b0));
`ifdef ADDER_SAT_EN
        tbl.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1));
        tbl.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1));
        tbl.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1));
        tbl.push_back(mk(16'h1000, 16'h2000, 1'b0, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b0));
`endif
        picks[0] = 16'hFFFF; picks[1] = 16'h8000; picks[2] = 16'h7FFF; picks[3] = 16'h0000;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0; sat = 1'b0;
        @(negedge clk);

        // Reset state
        tick(acc);
        tick(acc);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Backpressure: 8 back-to-back beats, out_ready alternating
        base = popped;
        sent = 0;
        cyc  = 0;
        while ((sent < 8 || out_valid === 1'b1 || q.size() != 0) && cyc < 100) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 8);
            a = W'(sent); b = W'(sent); ci = 1'b0; sub = 1'b0; sat = 1'b0;
            tick(acc);
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_finished", (cyc < 100), 1);
        chk("bp_count", popped - base, 8);

        // Reset with beats in flight; a beat offered during reset must be ignored
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'(16'h0100 + i); b = 16'h0001; sub = 1'b0;
            tick(acc);
        end
        rst_n = 1'b0;
        in_valid = 1'b1;
        tick(acc);
        chk("rst_beat_accept", acc, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) seen++;
            tick(acc);
        end
        chk("no_stale", seen, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a   = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
            ci  = 1'($urandom);
            sub = 1'($urandom);
            sat = 1'($urandom);
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick(acc);
        chk("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
